// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the ID operand stage.
// Holds the conditional-write encodings, the hard-wired zero register
// address, the NOP operation codes driven into bubbles, the FSM state
// type and the stall-counter saturation value.
package id_operand_stage_pkg;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_NZ     = 2'b01,
        COND_Z      = 2'b10,
        COND_NEVER  = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    localparam int unsigned REG_ZERO      = 0;
    localparam int unsigned NOP_ALUOP     = 0;
    localparam int unsigned NOP_ALUSEL    = 0;
    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    // True when the conditional-write code lets the write through.
    function automatic logic cond_allows(logic [1:0] cond, logic op2_zero);
        logic ok;
        case (cond)
            COND_ALWAYS: ok = 1'b1;
            COND_NZ:     ok = !op2_zero;
            COND_Z:      ok = op2_zero;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Decode-to-execute bus of the ID operand stage.
// dec_*   : decoded instruction fields presented by the decoder.
// ex_*    : registered ID/EX fields presented to the execute stage.
// master  : decoder/execute side (drives dec_*, observes ex_*).
// slave   : the operand stage itself (consumes dec_*, drives ex_*).
interface id_operand_stage_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
);
    logic                dec_valid;
    logic                rd1_en;
    logic                rd2_en;
    logic [ADDR_W-1:0]   rd1_addr;
    logic [ADDR_W-1:0]   rd2_addr;
    logic [DATA_W-1:0]   imm;
    logic [ADDR_W-1:0]   dec_wd;
    logic                dec_wreg;
    logic [1:0]          dec_cond;
    logic [ALUOP_W-1:0]  dec_aluop;
    logic [ALUSEL_W-1:0] dec_alusel;

    logic                ex_valid;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_reg1;
    logic [DATA_W-1:0]   ex_reg2;
    logic [ADDR_W-1:0]   ex_wd;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [ALUSEL_W-1:0] ex_alusel;

    modport master (
        output dec_valid, rd1_en, rd2_en, rd1_addr, rd2_addr, imm,
               dec_wd, dec_wreg, dec_cond, dec_aluop, dec_alusel,
        input  ex_valid, ex_wreg, ex_reg1, ex_reg2, ex_wd, ex_aluop, ex_alusel
    );

    modport slave (
        input  dec_valid, rd1_en, rd2_en, rd1_addr, rd2_addr, imm,
               dec_wd, dec_wreg, dec_cond, dec_aluop, dec_alusel,
        output ex_valid, ex_wreg, ex_reg1, ex_reg2, ex_wd, ex_aluop, ex_alusel
    );
endinterface

// File: rtl/id_operand_stage_operand_resolve.sv
// Resolves one source operand of the instruction in decode.
// rd_en_i/rd_addr_i : register read request; imm_i used when not reading.
// rf_data_i         : register file read data for rd_addr_i.
// fwd_*_i           : packed forwarding sources, index 0 is the youngest.
// operand_o         : resolved operand value.
// load_use_o        : the selected forwarding source is a load whose data
//                     is not available yet.
module operand_resolve
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_FWD  = 2
) (
    input  logic                      rd_en_i,
    input  logic [ADDR_W-1:0]         rd_addr_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [DATA_W-1:0]         rf_data_i,
    input  logic [N_FWD-1:0]          fwd_wreg_i,
    input  logic [N_FWD*ADDR_W-1:0]   fwd_wd_i,
    input  logic [N_FWD*DATA_W-1:0]   fwd_wdata_i,
    input  logic [N_FWD-1:0]          fwd_is_load_i,
    output logic [DATA_W-1:0]         operand_o,
    output logic                      load_use_o
);
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              hit_load;
    logic              addr_zero;

    assign addr_zero = (rd_addr_i == ADDR_W'(REG_ZERO));

    // Scan oldest to youngest so the youngest matching source wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        hit_load = 1'b0;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (fwd_wreg_i[i] && (fwd_wd_i[i*ADDR_W +: ADDR_W] == rd_addr_i)) begin
                hit      = 1'b1;
                hit_data = fwd_wdata_i[i*DATA_W +: DATA_W];
                hit_load = fwd_is_load_i[i];
            end
        end
    end

    always_comb begin
        operand_o = rf_data_i;
        if (!rd_en_i) begin
            operand_o = imm_i;
        end else if (addr_zero) begin
            operand_o = '0;
        end else if (hit) begin
            operand_o = hit_data;
        end
    end

    assign load_use_o = rd_en_i && !addr_zero && hit && hit_load;

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: resolves both operands (immediate, zero register,
// forwarding, register file), detects load-use hazards, evaluates the
// conditional write enable and holds the ID/EX pipeline register.
// clk, rst          : clock, synchronous active-high reset.
// bus (slave)       : decoded fields in, ID/EX register fields out.
// rf_data1/2        : register file read data.
// fwd_*             : forwarding sources, index 0 youngest.
// stall_i, flush_i  : downstream busy, squash.
// stall_o           : hold IF/ID this cycle.
// stall_cnt         : saturating count of stalled cycles.
//
// state     | meaning
// ST_RUN    | issuing normally
// ST_HOLD   | downstream busy, ID/EX register frozen
// ST_BUBBLE | a load-use bubble was inserted last edge
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_FWD    = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    id_operand_stage_if.slave       bus,
    input  logic [DATA_W-1:0]       rf_data1,
    input  logic [DATA_W-1:0]       rf_data2,
    input  logic [N_FWD-1:0]        fwd_wreg,
    input  logic [N_FWD*ADDR_W-1:0] fwd_wd,
    input  logic [N_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [N_FWD-1:0]        fwd_is_load,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic                    stall_o,
    output logic [31:0]             stall_cnt
);
    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                wreg_q, wreg_d;
    logic [DATA_W-1:0]   reg1_q, reg1_d;
    logic [DATA_W-1:0]   reg2_q, reg2_d;
    logic [ADDR_W-1:0]   wd_q, wd_d;
    logic [ALUOP_W-1:0]  aluop_q, aluop_d;
    logic [ALUSEL_W-1:0] alusel_q, alusel_d;
    logic [31:0]         cnt_q, cnt_d;

    logic [DATA_W-1:0]   op1, op2;
    logic                lu1, lu2;
    logic                hazard;
    logic                take_bubble, take_dec;

    operand_resolve #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD)) u_op1 (
        .rd_en_i       (bus.rd1_en),
        .rd_addr_i     (bus.rd1_addr),
        .imm_i         (bus.imm),
        .rf_data_i     (rf_data1),
        .fwd_wreg_i    (fwd_wreg),
        .fwd_wd_i      (fwd_wd),
        .fwd_wdata_i   (fwd_wdata),
        .fwd_is_load_i (fwd_is_load),
        .operand_o     (op1),
        .load_use_o    (lu1)
    );

    operand_resolve #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD)) u_op2 (
        .rd_en_i       (bus.rd2_en),
        .rd_addr_i     (bus.rd2_addr),
        .imm_i         (bus.imm),
        .rf_data_i     (rf_data2),
        .fwd_wreg_i    (fwd_wreg),
        .fwd_wd_i      (fwd_wd),
        .fwd_wdata_i   (fwd_wdata),
        .fwd_is_load_i (fwd_is_load),
        .operand_o     (op2),
        .load_use_o    (lu2)
    );

    // An empty slot never stalls the pipe.
    assign hazard  = bus.dec_valid && (lu1 || lu2);
    assign stall_o = !flush_i && (stall_i || hazard);

    // HOLD and BUBBLE leave through the same evaluation as RUN, so the
    // hazard is re-checked in the cycle the stall releases.
    always_comb begin
        take_bubble = flush_i || (!stall_i && (hazard || !bus.dec_valid));
        take_dec    = !flush_i && !stall_i && !hazard && bus.dec_valid;

        state_d = ST_RUN;
        if (!flush_i && stall_i) begin
            state_d = ST_HOLD;
        end else if (!flush_i && hazard) begin
            state_d = ST_BUBBLE;
        end

        valid_d  = valid_q;
        wreg_d   = wreg_q;
        reg1_d   = reg1_q;
        reg2_d   = reg2_q;
        wd_d     = wd_q;
        aluop_d  = aluop_q;
        alusel_d = alusel_q;
        if (take_bubble) begin
            valid_d  = 1'b0;
            wreg_d   = 1'b0;
            reg1_d   = '0;
            reg2_d   = '0;
            wd_d     = '0;
            aluop_d  = ALUOP_W'(NOP_ALUOP);
            alusel_d = ALUSEL_W'(NOP_ALUSEL);
        end else if (take_dec) begin
            valid_d  = 1'b1;
            wreg_d   = bus.dec_wreg && cond_allows(bus.dec_cond, (op2 == '0));
            reg1_d   = op1;
            reg2_d   = op2;
            wd_d     = bus.dec_wd;
            aluop_d  = bus.dec_aluop;
            alusel_d = bus.dec_alusel;
        end

        cnt_d = cnt_q;
        if (stall_o && (cnt_q != STALL_CNT_MAX)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            wreg_q   <= 1'b0;
            reg1_q   <= '0;
            reg2_q   <= '0;
            wd_q     <= '0;
            aluop_q  <= ALUOP_W'(NOP_ALUOP);
            alusel_q <= ALUSEL_W'(NOP_ALUSEL);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            wreg_q   <= wreg_d;
            reg1_q   <= reg1_d;
            reg2_q   <= reg2_d;
            wd_q     <= wd_d;
            aluop_q  <= aluop_d;
            alusel_q <= alusel_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ex_valid  = valid_q;
    assign bus.ex_wreg   = wreg_q;
    assign bus.ex_reg1   = reg1_q;
    assign bus.ex_reg2   = reg2_q;
    assign bus.ex_wd     = wd_q;
    assign bus.ex_aluop  = aluop_q;
    assign bus.ex_alusel = alusel_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_id_operand_stage;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int N_FWD    = 2;
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] rf_data1, rf_data2;
    logic        f_wreg  [N_FWD];
    logic [4:0]  f_wd    [N_FWD];
    logic [31:0] f_wdata [N_FWD];
    logic        f_load  [N_FWD];

    logic [N_FWD-1:0]        fwd_wreg, fwd_is_load;
    logic [N_FWD*ADDR_W-1:0] fwd_wd;
    logic [N_FWD*DATA_W-1:0] fwd_wdata;
    logic                    stall_i, flush_i, stall_o;
    logic [31:0]             stall_cnt;

    always_comb begin
        fwd_wreg    = '0;
        fwd_is_load = '0;
        fwd_wd      = '0;
        fwd_wdata   = '0;
        for (int i = 0; i < N_FWD; i++) begin
            fwd_wreg[i]                   = f_wreg[i];
            fwd_is_load[i]                = f_load[i];
            fwd_wd[i*ADDR_W +: ADDR_W]    = f_wd[i];
            fwd_wdata[i*DATA_W +: DATA_W] = f_wdata[i];
        end
    end

    id_operand_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W),
                          .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) bus ();

    id_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD),
                       .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rf_data1   (rf_data1),
        .rf_data2   (rf_data2),
        .fwd_wreg   (fwd_wreg),
        .fwd_wd     (fwd_wd),
        .fwd_wdata  (fwd_wdata),
        .fwd_is_load(fwd_is_load),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .stall_cnt  (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Expected ID/EX contents; m_dc marks the data fields of a bubble as don't-care.
    logic        m_valid, m_wreg, m_dc;
    logic [31:0] m_reg1, m_reg2, m_cnt;
    logic [4:0]  m_wd;
    logic [7:0]  m_aluop;
    logic [2:0]  m_alusel;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operand selection straight from the stage's rules: youngest matching source first.
    function automatic logic [31:0] ref_operand(logic en, logic [4:0] a, logic [31:0] imm,
                                                logic [31:0] rf, output logic lu);
        lu = 1'b0;
        if (!en) return imm;
        if (a == 5'd0) return 32'd0;
        for (int i = 0; i < N_FWD; i++) begin
            if (f_wreg[i] && f_wd[i] == a) begin
                lu = f_load[i];
                return f_wdata[i];
            end
        end
        return rf;
    endfunction

    task automatic set_idle();
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        rf_data1 = '0; rf_data2 = '0;
        for (int i = 0; i < N_FWD; i++) begin
            f_wreg[i] = 1'b0; f_wd[i] = '0; f_wdata[i] = '0; f_load[i] = 1'b0;
        end
        bus.dec_valid = 1'b0; bus.rd1_en = 1'b0; bus.rd2_en = 1'b0;
        bus.rd1_addr = '0; bus.rd2_addr = '0; bus.imm = '0; bus.dec_wd = '0;
        bus.dec_wreg = 1'b0; bus.dec_cond = 2'b00; bus.dec_aluop = '0; bus.dec_alusel = '0;
    endtask

    task automatic set_dec(logic v, logic e1, logic [4:0] a1, logic e2, logic [4:0] a2,
                           logic [31:0] imm, logic [4:0] wd, logic wr, logic [1:0] cond,
                           logic [7:0] op, logic [2:0] sel);
        bus.dec_valid = v; bus.rd1_en = e1; bus.rd1_addr = a1; bus.rd2_en = e2;
        bus.rd2_addr = a2; bus.imm = imm; bus.dec_wd = wd; bus.dec_wreg = wr;
        bus.dec_cond = cond; bus.dec_aluop = op; bus.dec_alusel = sel;
    endtask

    // One clock: check stall_o mid-cycle, advance the model, check the register after the edge.
    task automatic cycle();
        logic [31:0] o1, o2;
        logic l1, l2, hz, es, wen;
        #3;
        o1 = ref_operand(bus.rd1_en, bus.rd1_addr, bus.imm, rf_data1, l1);
        o2 = ref_operand(bus.rd2_en, bus.rd2_addr, bus.imm, rf_data2, l2);
        hz = bus.dec_valid && (l1 || l2);
        es = !flush_i && (stall_i || hz);
        chk("stall_o", 32'(stall_o), 32'(es));
        case (bus.dec_cond)
            2'b00:   wen = bus.dec_wreg;
            2'b01:   wen = bus.dec_wreg && (o2 != 0);
            2'b10:   wen = bus.dec_wreg && (o2 == 0);
            default: wen = 1'b0;
        endcase
        if (rst) begin
            m_valid = 0; m_wreg = 0; m_reg1 = 0; m_reg2 = 0; m_wd = 0;
            m_aluop = 0; m_alusel = 0; m_cnt = 0; m_dc = 0;
        end else begin
            if (es && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (flush_i || (!stall_i && (hz || !bus.dec_valid))) begin
                m_valid = 0; m_wreg = 0; m_aluop = 0; m_alusel = 0; m_dc = 1;
            end else if (!stall_i) begin
                m_valid = 1; m_wreg = wen; m_reg1 = o1; m_reg2 = o2; m_wd = bus.dec_wd;
                m_aluop = bus.dec_aluop; m_alusel = bus.dec_alusel; m_dc = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("ex_wreg", 32'(bus.ex_wreg), 32'(m_wreg));
        chk("ex_aluop", 32'(bus.ex_aluop), 32'(m_aluop));
        chk("ex_alusel", 32'(bus.ex_alusel), 32'(m_alusel));
        chk("stall_cnt", stall_cnt, m_cnt);
        if (!m_dc) begin
            chk("ex_reg1", bus.ex_reg1, m_reg1);
            chk("ex_reg2", bus.ex_reg2, m_reg2);
            chk("ex_wd", 32'(bus.ex_wd), 32'(m_wd));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        do_reset();
        chk("reset_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset_reg1", bus.ex_reg1, 32'd0);
        chk("reset_cnt", stall_cnt, 32'd0);

        // Youngest forwarding source wins.
        set_dec(1, 1, 5'd3, 1, 5'd4, 32'd0, 5'd6, 1, 2'b00, 8'h21, 3'd1);
        rf_data1 = 32'h1111; rf_data2 = 32'h4444;
        f_wreg[0] = 1; f_wd[0] = 5'd3; f_wdata[0] = 32'hAAAA;
        f_wreg[1] = 1; f_wd[1] = 5'd3; f_wdata[1] = 32'hBBBB;
        cycle();
        chk("fwd_youngest", bus.ex_reg1, 32'hAAAA);

        // Register zero is never forwarded.
        set_idle();
        set_dec(1, 0, 5'd0, 1, 5'd0, 32'h9, 5'd2, 1, 2'b00, 8'h3, 3'd2);
        f_wreg[0] = 1; f_wd[0] = 5'd0; f_wdata[0] = 32'h1234; rf_data2 = 32'h55;
        cycle();
        chk("zero_addr_reg2", bus.ex_reg2, 32'd0);
        chk("zero_addr_nostall", stall_cnt, 32'd0);

        // Load-use: one bubble, then the forwarded value issues.
        set_idle();
        do_reset();
        set_dec(1, 1, 5'd5, 0, 5'd0, 32'h0, 5'd7, 1, 2'b00, 8'h11, 3'd3);
        f_wreg[0] = 1; f_wd[0] = 5'd5; f_wdata[0] = 32'hDEAD; f_load[0] = 1;
        cycle();
        chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
        f_load[0] = 0; f_wdata[0] = 32'hCAFE;
        cycle();
        chk("lu_issue_reg1", bus.ex_reg1, 32'hCAFE);
        chk("lu_issue_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // Downstream stall for three cycles.
        set_idle();
        do_reset();
        set_dec(1, 0, 5'd0, 0, 5'd0, 32'h1000, 5'd8, 1, 2'b00, 8'h5, 3'd1);
        cycle();
        set_dec(1, 0, 5'd0, 0, 5'd0, 32'h2000, 5'd9, 1, 2'b00, 8'h6, 3'd2);
        stall_i = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("hold_reg1", bus.ex_reg1, 32'h1000);
        end
        chk("hold_stall_cnt", stall_cnt, 32'd3);
        stall_i = 0;
        cycle();
        chk("hold_release_reg1", bus.ex_reg1, 32'h2000);

        // Conditional write on the resolved operand 2.
        set_idle();
        set_dec(1, 0, 5'd0, 1, 5'd9, 32'h0, 5'd4, 1, 2'b01, 8'h1, 3'd1);
        rf_data2 = 32'd0; cycle(); chk("cond_nz_zero", 32'(bus.ex_wreg), 32'd0);
        rf_data2 = 32'd7; cycle(); chk("cond_nz_seven", 32'(bus.ex_wreg), 32'd1);
        bus.dec_cond = 2'b10;
        rf_data2 = 32'd0; cycle(); chk("cond_z_zero", 32'(bus.ex_wreg), 32'd1);
        rf_data2 = 32'd7; cycle(); chk("cond_z_seven", 32'(bus.ex_wreg), 32'd0);
        bus.dec_cond = 2'b01; f_wreg[0] = 1; f_wd[0] = 5'd9; f_wdata[0] = 32'd0;
        cycle(); chk("cond_nz_fwd_zero", 32'(bus.ex_wreg), 32'd0);
        bus.dec_cond = 2'b11;
        cycle(); chk("cond_never", 32'(bus.ex_wreg), 32'd0);

        // Flush during hold, then reset during a bubble.
        set_idle();
        set_dec(1, 0, 5'd0, 0, 5'd0, 32'h77, 5'd3, 1, 2'b00, 8'h9, 3'd4);
        cycle();
        stall_i = 1; cycle();
        flush_i = 1; cycle();
        chk("flush_hold_valid", 32'(bus.ex_valid), 32'd0);
        stall_i = 0; flush_i = 0; cycle();
        chk("flush_then_run", 32'(bus.ex_valid), 32'd1);
        set_dec(1, 1, 5'd6, 0, 5'd0, 32'h0, 5'd3, 1, 2'b00, 8'h9, 3'd4);
        f_wreg[0] = 1; f_wd[0] = 5'd6; f_load[0] = 1; f_wdata[0] = 32'h66;
        cycle();
        rst = 1; cycle(); rst = 0;
        chk("rst_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_bubble_reg1", bus.ex_reg1, 32'd0);
        chk("rst_bubble_aluop", 32'(bus.ex_aluop), 32'd0);
        chk("rst_bubble_cnt", stall_cnt, 32'd0);

        // Randomized traffic.
        set_idle();
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 59) == 0);
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 19) == 0);
            rf_data1 = $urandom; rf_data2 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            for (int i = 0; i < N_FWD; i++) begin
                f_wreg[i]  = $urandom_range(0, 1);
                f_wd[i]    = 5'($urandom_range(0, 7));
                f_wdata[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                f_load[i]  = ($urandom_range(0, 3) == 0);
            end
            set_dec(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), $urandom, 5'($urandom),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom), 3'($urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter N_FWD, default 2, number of forwarding sources (index 0 = youngest stage).
REQ-004 SHALL have parameters ALUOP_W, default 8, and ALUSEL_W, default 3, operation/type code widths.
REQ-005 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have decoder-side inputs: dec_valid 1; rd1_en, rd2_en 1 each; rd1_addr, rd2_addr ADDR_W; imm DATA_W; dec_wd ADDR_W; dec_wreg 1; dec_cond 2 (00 always, 01 write if op2!=0, 10 write if op2==0, 11 never); dec_aluop ALUOP_W; dec_alusel ALUSEL_W.
REQ-007 SHALL have inputs rf_data1, rf_data2 DATA_W (register file read data, same cycle).
REQ-008 SHALL have inputs fwd_wreg N_FWD, fwd_wd N_FWD*ADDR_W, fwd_wdata N_FWD*DATA_W, fwd_is_load N_FWD (packed, source i at slice i).
REQ-009 SHALL have inputs stall_i 1 (downstream busy, e.g. multi-cycle divide) and flush_i 1 (squash).
REQ-010 SHALL have outputs ex_valid, ex_wreg 1; ex_reg1, ex_reg2 DATA_W; ex_wd ADDR_W; ex_aluop ALUOP_W; ex_alusel ALUSEL_W; stall_o 1 (hold IF/ID); stall_cnt 32 (saturating).

Function
REQ-011 Operand n SHALL be: rd_en=0 -> imm; rd_addr==0 -> 0; else fwd_wdata of lowest index i with fwd_wreg[i]=1 and fwd_wd[i]==rd_addr; else rf_data.
REQ-012 Address 0 SHALL never be forwarded and never cause a hazard.
REQ-013 Load-use hazard SHALL be flagged when for any i fwd_is_load[i]=1, fwd_wreg[i]=1, fwd_wd[i]==enabled nonzero read address, and the matching source is the selected one per REQ-011.
REQ-014 Write enable SHALL be dec_wreg AND the condition per dec_cond evaluated on the resolved (forwarded) operand 2.
REQ-015 FSM states RUN, HOLD, BUBBLE; reset state RUN.
REQ-016 RUN: stall_i=1 -> HOLD; load-use hazard (stall_i=0) -> BUBBLE; else stay RUN.
REQ-017 HOLD: ID/EX register keeps value, stall_o=1; exit to RUN when stall_i=0 (re-evaluate hazard that cycle).
REQ-018 BUBBLE: register loads ex_valid=0, ex_wreg=0, aluop/alusel=0; stall_o=1 that cycle; next cycle RUN.
REQ-019 In RUN without hazard, register SHALL load decoded values with ex_valid=dec_valid, one-cycle latency.
REQ-020 dec_valid=0 SHALL load a bubble and never raise a hazard.
REQ-021 flush_i=1 SHALL override all: next edge loads bubble, state RUN, stall_o=0 that cycle.
REQ-022 stall_o SHALL be combinational: 1 when stall_i=1 or load-use hazard, and flush_i=0.
REQ-023 stall_cnt SHALL increment each cycle stall_o=1, saturate at 32'hFFFF_FFFF.

Reset
REQ-024 On rst=1 at clock edge: state RUN, ex_valid=0, ex_wreg=0, ex_reg1=ex_reg2=0, ex_wd=0, ex_aluop=0, ex_alusel=0, stall_cnt=0.
REQ-025 rst SHALL override flush_i and stall_i; rst mid-HOLD returns to RUN with empty register.

Structure
REQ-026 cond encodings, zero-address constant and NOP aluop/alusel codes SHALL live in the shared defines package.
REQ-027 Operand resolution SHALL be one sub-module, operand_resolve, instantiated twice (operand 1, operand 2), each reporting its load-use flag.

Verification
REQ-028 rd1_addr=3, fwd0 wd=3 wdata=0xAAAA, fwd1 wd=3 wdata=0xBBBB, both wreg -> ex_reg1=0xAAAA next cycle.
REQ-029 rd2_addr=0, fwd0 wd=0 wdata=0x1234 wreg=1, rf_data2=0x55 -> ex_reg2=0, no stall.
REQ-030 fwd0 is_load=1 wd=5, rd1_addr=5 -> stall_o=1 one cycle, bubble loaded, then instruction issued with forwarded value, stall_cnt=1.
REQ-031 stall_i high 3 cycles -> ex_* unchanged 3 cycles, stall_cnt=3, issue on 4th edge.
REQ-032 dec_cond=01, resolved op2=0 -> ex_wreg=0; op2=7 -> ex_wreg=1; dec_cond=10 inverse.
REQ-033 flush_i during HOLD -> bubble loaded, state RUN; rst during BUBBLE -> all outputs 0.
